// File: rtl/fused_load_pkg.sv
// Shared types for the fused-layer load path.
// Load-type encoding is also used by the load router.
package fused_load_pkg;

  typedef logic [1:0] load_type_t;

  localparam load_type_t NO_LOAD       = 2'd0;
  localparam load_type_t LOAD_IFM_C    = 2'd1;
  localparam load_type_t LOAD_WEIGHT_C = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_IFM,
    ST_LOAD_WEIGHT,
    ST_FINISH
  } load_state_t;

endpackage

// File: rtl/fused_load_sequencer_counter.sv
// Beat counter shared by both load phases.
// Terminal flag compares against a per-phase limit.
module load_beat_counter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] limit,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  at_limit
);

  // Clear wins over increment so the last beat wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ADDR_WIDTH'(1);
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/fused_load_sequencer.sv
// Sequences an IFM phase then a weight phase into
// the fused load router, one write per accepted beat.
module fused_load_sequencer
  import fused_load_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] size_IFM,
  input  logic [ADDR_WIDTH-1:0] size_Weight_layer_1,
  input  logic [ADDR_WIDTH-1:0] size_Weight_layer_2,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr_fused,
  output logic                  we_fused,
  output logic [1:0]            control_load,
  output logic [DATA_WIDTH-1:0] wr_data_fused,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  load_state_t           state;
  logic [ADDR_WIDTH-1:0] size_ifm_q;
  logic [ADDR_WIDTH-1:0] size_w1_q;
  logic [ADDR_WIDTH-1:0] size_w2_q;
  logic [ADDR_WIDTH-1:0] w_total;
  logic [ADDR_WIDTH-1:0] start_w;
  logic [ADDR_WIDTH-1:0] limit;
  logic [ADDR_WIDTH-1:0] count;
  logic                  at_limit;
  logic                  accept;
  logic                  cnt_clr;
  logic                  phase_end;

  // Carry out of the weight sum is dropped by the sized add.
  assign start_w = size_Weight_layer_1 + size_Weight_layer_2;
  assign w_total = size_w1_q + size_w2_q;

  assign in_ready  = (state == ST_LOAD_IFM) ||
                     (state == ST_LOAD_WEIGHT);
  assign accept    = in_valid & in_ready;
  assign phase_end = accept & at_limit;
  assign cnt_clr   = (state == ST_IDLE) | phase_end;

  // One counter, re-pointed at the active phase's last index.
  always_comb begin
    limit = w_total - ONE;
    unique case (1'b1)
      (state == ST_LOAD_IFM): limit = size_ifm_q - ONE;
      default:                limit = w_total - ONE;
    endcase
  end

  load_beat_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (accept),
    .limit   (limit),
    .count   (count),
    .at_limit(at_limit)
  );

  // Phase FSM with registered write-port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      size_ifm_q    <= '0;
      size_w1_q     <= '0;
      size_w2_q     <= '0;
      wr_addr_fused <= '0;
      wr_data_fused <= '0;
      we_fused      <= 1'b0;
      control_load  <= NO_LOAD;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      we_fused <= accept;
      done     <= 1'b0;
      if (accept) begin
        wr_addr_fused <= count;
        wr_data_fused <= in_data;
        control_load  <= (state == ST_LOAD_IFM) ?
                         LOAD_IFM_C : LOAD_WEIGHT_C;
      end
      unique case (state)
        ST_IDLE: begin
          control_load <= NO_LOAD;
          if (start) begin
            size_ifm_q <= size_IFM;
            size_w1_q  <= size_Weight_layer_1;
            size_w2_q  <= size_Weight_layer_2;
            busy       <= 1'b1;
            if (size_IFM != '0) begin
              state <= ST_LOAD_IFM;
            end else if (start_w != '0) begin
              state <= ST_LOAD_WEIGHT;
            end else begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end
          end
        end
        ST_LOAD_IFM: begin
          if (phase_end) begin
            if (w_total != '0) begin
              state <= ST_LOAD_WEIGHT;
            end else begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end
          end
        end
        ST_LOAD_WEIGHT: begin
          if (phase_end) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          control_load <= NO_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fused_load_sequencer.sv
// Scoreboard bench for fused_load_sequencer.
// Expected writes are queued from the sizes at start.
module tb_fused_load_sequencer;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    ctl;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] size_IFM = '0;
  logic [AW-1:0] size_Weight_layer_1 = '0;
  logic [AW-1:0] size_Weight_layer_2 = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] wr_addr_fused;
  logic          we_fused;
  logic [1:0]    control_load;
  logic [DW-1:0] wr_data_fused;
  logic          busy;
  logic          done;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  int   rdy_cnt = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   first_wr = -1;
  int   last_wr = -1;
  bit   mon_en = 1'b1;
  bit   chk_busy = 1'b0;

  fused_load_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .size_IFM           (size_IFM),
    .size_Weight_layer_1(size_Weight_layer_1),
    .size_Weight_layer_2(size_Weight_layer_2),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .wr_addr_fused      (wr_addr_fused),
    .we_fused           (we_fused),
    .control_load       (control_load),
    .wr_data_fused      (wr_data_fused),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_in_ready"}, 64'(in_ready), 0);
    check({pfx, "_wr_addr"}, 64'(wr_addr_fused), 0);
    check({pfx, "_we"}, 64'(we_fused), 0);
    check({pfx, "_ctl"}, 64'(control_load), 0);
    check({pfx, "_wr_data"}, 64'(wr_data_fused), 0);
    check({pfx, "_busy"}, 64'(busy), 0);
    check({pfx, "_done"}, 64'(done), 0);
  endtask

  // Output monitor: pops the scoreboard on every write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (in_ready) rdy_cnt++;
      if (done) done_cnt++;
      if (chk_busy) begin
        check("busy_after_done", 64'(busy), 0);
        chk_busy = 1'b0;
      end
      if (we_fused) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc_n;
        last_wr = cyc_n;
        if (mon_en) begin
          check("queue_nonempty", 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr_fused), 64'(e.addr));
            check("wr_data", 64'(wr_data_fused), 64'(e.data));
            check("ctl", 64'(control_load), 64'(e.ctl));
            check("done_w_last", 64'(done), 64'(e.last));
            if (e.last) chk_busy = 1'b1;
          end
        end
      end else if (done && mon_en) begin
        check("done_no_write_q", 64'(exp_q.size()), 0);
      end
    end
  end

  task automatic run_job(input int ifm, input int l1,
                         input int l2, input bit gap,
                         input bit mid_start);
    exp_t e;
    int   w;
    int   total;
    int   idx;
    int   cyc;
    int   done0;
    int   rdy0;
    int   wr0;
    bit   acc;
    w     = l1 + l2;
    total = ifm + w;
    for (int i = 0; i < ifm; i++) begin
      e.addr = AW'(i);
      e.data = DW'(i);
      e.ctl  = 2'd1;
      e.last = (w == 0) && (i == ifm - 1);
      exp_q.push_back(e);
    end
    for (int j = 0; j < w; j++) begin
      e.addr = AW'(j);
      e.data = DW'(ifm + j);
      e.ctl  = 2'd2;
      e.last = (j == w - 1);
      exp_q.push_back(e);
    end
    first_wr = -1;
    done0    = done_cnt;
    rdy0     = rdy_cnt;
    wr0      = wr_cnt;
    @(negedge clk);
    size_IFM            = AW'(ifm);
    size_Weight_layer_1 = AW'(l1);
    size_Weight_layer_2 = AW'(l2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_start", 64'(busy), 1);
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 500) begin
      in_valid = gap ? ~cyc[0] : 1'b1;
      in_data  = DW'(idx);
      if (mid_start && cyc == 3) begin
        start               = 1'b1;
        size_IFM            = 7;
        size_Weight_layer_1 = 7;
        size_Weight_layer_2 = 7;
      end else begin
        start = 1'b0;
      end
      acc = in_valid & in_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("beats_sent", 64'(idx), 64'(total));
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    check("busy_low", 64'(busy), 0);
    @(negedge clk);
    check("ctl_idle", 64'(control_load), 0);
    check("done_once", 64'(done_cnt - done0), 1);
    check("writes", 64'(wr_cnt - wr0), 64'(total));
    check("queue_empty", 64'(exp_q.size()), 0);
    if (total == 0)
      check("no_ready", 64'(rdy_cnt - rdy0), 0);
    if (!gap && total > 0)
      check("contiguous", 64'(last_wr - first_wr),
            64'(total - 1));
    size_IFM            = '0;
    size_Weight_layer_1 = '0;
    size_Weight_layer_2 = '0;
  endtask

  initial begin
    int idx;
    int done0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(4, 3, 2, 1'b0, 1'b0);
    run_job(4, 3, 2, 1'b1, 1'b0);
    run_job(0, 2, 0, 1'b0, 1'b0);
    run_job(0, 0, 0, 1'b0, 1'b0);
    run_job(4, 3, 2, 1'b0, 1'b1);
    run_job(1, 0, 2, 1'b1, 1'b0);

    mon_en = 1'b0;
    done0  = done_cnt;
    @(negedge clk);
    size_IFM            = 4;
    size_Weight_layer_1 = 3;
    size_Weight_layer_2 = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(idx);
      if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = DW'(idx);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_done", 64'(done_cnt - done0), 0);
    exp_q.delete();
    mon_en = 1'b1;
    run_job(1, 0, 0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
